sb_dma_m1: RTL

- Single-channel word-copy DMA engine acting as the second bus master on the system bus (sb) m1 port, beside the core on m0.
- Core programs source address, destination address and word count through a small register port, then sets start.
- Engine copies memory-to-memory through sb: read one word, write one word, repeat.
- Reports busy/done status and an optional interrupt.

---
 rtl/sb_dma_m1_if.sv | 24 ++
 rtl/sb_dma_m1.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/sb_dma_m1_if.sv
// System-bus m1 port bundle shared by the DMA master and the bus fabric.
interface sb_dma_m1_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              m1_gnt;
  logic              m1_un_sign;
  logic [3:0]        m1_byte_mask;
  logic              m1_re;
  logic              m1_we;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic [DATA_W-1:0] m1_rdata;

  modport master (
    input  m1_gnt, m1_rdata,
    output m1_un_sign, m1_byte_mask, m1_re, m1_we, m1_addr, m1_wdata
  );

  modport slave (
    output m1_gnt, m1_rdata,
    input  m1_un_sign, m1_byte_mask, m1_re, m1_we, m1_addr, m1_wdata
  );
endinterface

// File: rtl/sb_dma_m1.sv
// Single-channel word-copy DMA engine on system-bus port m1.
// Optional completion interrupt enabled by defining SB_DMA_IRQ_EN.
module sb_dma_m1 #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [1:0]        cfg_addr,
  input  logic [DATA_W-1:0] cfg_wdata,
  output logic [DATA_W-1:0] cfg_rdata,
  sb_dma_m1_if.master       m1,
  output logic              busy,
  output logic              irq
);

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, FIN} state_t;

  state_t            state;
  logic [ADDR_W-1:0] src_reg, dst_reg, cur_src, cur_dst, addr_q;
  logic [LEN_W-1:0]  len_reg, remaining;
  logic [DATA_W-1:0] wdata_q;
  logic              re_q, we_q, busy_q, done_q, err_q;
  logic [ADDR_W:0]   src_inc, dst_inc;
  logic              wr_ctrl, start_req, clr_done;

  // Extra top bit catches the modulo-2^ADDR_W wrap.
  assign src_inc   = {1'b0, cur_src} + (ADDR_W+1)'(4);
  assign dst_inc   = {1'b0, cur_dst} + (ADDR_W+1)'(4);
  assign wr_ctrl   = cfg_we && (cfg_addr == 2'd3);
  assign start_req = wr_ctrl && cfg_wdata[0];
  assign clr_done  = wr_ctrl && cfg_wdata[2];

  assign m1.m1_un_sign   = 1'b1;
  assign m1.m1_byte_mask = (re_q || we_q) ? 4'b1111 : 4'b0000;
  assign m1.m1_re        = re_q;
  assign m1.m1_we        = we_q;
  assign m1.m1_addr      = addr_q;
  assign m1.m1_wdata     = wdata_q;
  assign busy            = busy_q;

`ifdef SB_DMA_IRQ_EN
  logic irq_en_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         irq_en_q <= 1'b0;
    else if (wr_ctrl) irq_en_q <= cfg_wdata[4];
  end

  assign irq = done_q & irq_en_q;
`else
  assign irq = 1'b0;
`endif

  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      2'd0: cfg_rdata[ADDR_W-1:0] = src_reg;
      2'd1: cfg_rdata[ADDR_W-1:0] = dst_reg;
      2'd2: cfg_rdata[LEN_W-1:0]  = len_reg;
      default: begin
        cfg_rdata[3:0] = {err_q, done_q, busy_q, 1'b0};
`ifdef SB_DMA_IRQ_EN
        cfg_rdata[4] = irq_en_q;
`endif
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      src_reg   <= '0;
      dst_reg   <= '0;
      len_reg   <= '0;
      cur_src   <= '0;
      cur_dst   <= '0;
      remaining <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      re_q      <= 1'b0;
      we_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      if (cfg_we && !busy_q) begin
        case (cfg_addr)
          2'd0:    src_reg <= {cfg_wdata[ADDR_W-1:2], 2'b00};
          2'd1:    dst_reg <= {cfg_wdata[ADDR_W-1:2], 2'b00};
          2'd2:    len_reg <= cfg_wdata[LEN_W-1:0];
          default: ;
        endcase
      end
      if (clr_done) done_q <= 1'b0;

      case (state)
        IDLE: begin
          if (start_req) begin
            err_q <= 1'b0;
            if (len_reg == '0) begin
              state <= FIN;
            end else begin
              cur_src   <= src_reg;
              cur_dst   <= dst_reg;
              remaining <= len_reg;
              addr_q    <= src_reg;
              re_q      <= 1'b1;
              busy_q    <= 1'b1;
              state     <= RD_REQ;
            end
          end
        end
        RD_REQ: begin
          if (m1.m1_gnt) begin
            re_q  <= 1'b0;
            state <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          wdata_q <= m1.m1_rdata;
          cur_src <= src_inc[ADDR_W-1:0];
          if (src_inc[ADDR_W]) err_q <= 1'b1;
          addr_q  <= cur_dst;
          we_q    <= 1'b1;
          state   <= WR_REQ;
        end
        WR_REQ: begin
          if (m1.m1_gnt) begin
            we_q      <= 1'b0;
            cur_dst   <= dst_inc[ADDR_W-1:0];
            remaining <= remaining - LEN_W'(1);
            if (dst_inc[ADDR_W]) err_q <= 1'b1;
            if (remaining == LEN_W'(1)) begin
              busy_q <= 1'b0;
              state  <= FIN;
            end else begin
              addr_q <= cur_src;
              re_q   <= 1'b1;
              state  <= RD_REQ;
            end
          end
        end
        FIN: begin
          done_q <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
